// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 pins,
// deserialises 11-bit frames, folds E0/F0 prefixes into flags and queues
// complete key events in a show-ahead FIFO for the IO keyboard path.
module ps2_kb_receiver #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          Fast_Clock,
    input  logic                          Raw_Reset_I,
    input  logic                          KB_Clk,
    input  logic                          KB_Data,
    input  logic                          Pop,
    output logic                          Key_Valid,
    output logic [7:0]                    Key_Code,
    output logic                          Key_Release,
    output logic                          Key_Extended,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Overflow,
    output logic                          Frame_Err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_ev_t;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          sample;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout, byte_done, err_nxt;

    logic          rel_pend, ext_pend;
    logic          push_req, do_push, do_pop, drop, full;
    key_ev_t       mem [FIFO_DEPTH];
    key_ev_t       head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Two-flop synchronisers; idle-high so reset does not fake a clock edge.
    always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], KB_Clk};
            dat_sync <= {dat_sync[0], KB_Data};
        end
    end

    // Glitch filter: follow the synced clock only after FILTER_LEN differing samples in a row.
    always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample  = filt_prev & ~filt_clk;
    assign timeout = (state != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next-state: timeout has priority and abandons the partial byte.
    always_comb begin
        state_nxt = state;
        byte_done = 1'b0;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (sample) begin
            case (state)
                IDLE:   if (dat_s) err_nxt = 1'b1;
                        else       state_nxt = DATA;
                DATA:   if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s && (^{shreg, par_bit})) byte_done = 1'b1;
                    else                              err_nxt   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state, shift register, parity capture and inter-sample timeout counter.
    always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            Frame_Err <= 1'b0;
        end else begin
            state     <= state_nxt;
            Frame_Err <= err_nxt;
            if (state == IDLE || sample) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;
            if (sample && !timeout) begin
                if (state == IDLE) bit_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= {dat_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == PARITY) par_bit <= dat_s;
            end
        end
    end

    assign push_req = byte_done && (shreg != 8'hF0) && (shreg != 8'hE0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_pop   = Pop && Key_Valid;
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    // Prefix flags; any non-prefix byte (pushed or dropped) consumes them.
    always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            rel_pend <= 1'b0;
            ext_pend <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            if (drop) Overflow <= 1'b1;
            if (byte_done) begin
                if (shreg == 8'hF0) begin
                    rel_pend <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else begin
                    rel_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end
            end
        end
    end

    // FIFO storage; contents need no reset since outputs are gated by count.
    always_ff @(posedge Fast_Clock) begin
        if (do_push) mem[wptr] <= '{ext: ext_pend, rel: rel_pend, code: shreg};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign Key_Valid    = (count != '0);
    assign head         = Key_Valid ? mem[rptr] : '0;
    assign Key_Code     = head.code;
    assign Key_Release  = head.rel;
    assign Key_Extended = head.ext;
    assign Fifo_Count   = count;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Scoreboarded bench for ps2_kb_receiver: frames are built bit by bit on the
// PS/2 pins, an abstract key-event model fills an expected queue, and an
// independent monitor checks every popped entry against it.
module tb_ps2_kb_receiver;

    localparam int DEPTH = 8;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int HALF  = 12;

    logic       clk = 1'b0, rst_n = 1'b0, kb_clk = 1'b1, kb_data = 1'b1, pop = 1'b0;
    logic       kv, krel, kext, ovf, ferr;
    logic [7:0] kc;
    logic [3:0] cnt;

    ps2_kb_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Fast_Clock(clk), .Raw_Reset_I(rst_n), .KB_Clk(kb_clk), .KB_Data(kb_data),
        .Pop(pop), .Key_Valid(kv), .Key_Code(kc), .Key_Release(krel),
        .Key_Extended(kext), .Fifo_Count(cnt), .Overflow(ovf), .Frame_Err(ferr)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0;
    int         exp_err = 0, err_seen = 0;
    logic [9:0] exp_q [$];
    bit         m_rel = 0, m_ext = 0, m_ovf = 0;
    bit         auto_pop = 0, force_pop = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Key-event model: prefixes set flags, other good bytes enqueue or drop.
    task automatic model_byte(input logic [7:0] b, input bit good, input bit pp);
        if (!good) exp_err++;
        else if (b == 8'hF0) m_rel = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (exp_q.size() >= DEPTH && !pp) m_ovf = 1;
            else exp_q.push_back({m_ext, m_rel, b});
            m_rel = 0;
            m_ext = 0;
        end
    endtask

    // Pop driver: random pops in auto mode, or a single forced pulse.
    initial forever begin
        @(posedge clk); #1;
        pop = force_pop || (auto_pop && kv && ($urandom_range(0, 2) != 0));
    end

    // Monitor: scoreboard compare on every accepted pop, Frame_Err pulse accounting.
    initial begin
        logic       err_prev;
        logic [9:0] e;
        err_prev = 0;
        forever begin
            @(negedge clk);
            if (ferr) err_seen++;
            if (ferr && err_prev) begin
                total++; bad++;
                $display("FAIL frame_err_width: high 2 cycles, required 1");
            end
            err_prev = ferr;
            if (pop && kv) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_entry: got %0h, required none", {kext, krel, kc});
                end else begin
                    e = exp_q.pop_front();
                    if ({kext, krel, kc} != e) begin
                        bad++;
                        $display("FAIL pop_entry: got %0h required %0h", {kext, krel, kc}, e);
                    end
                end
            end
        end
    end

    // One PS/2 bit: data set while clock high, then a low phase.
    task automatic ps2_bit(input logic d);
        kb_data = d;
        repeat (HALF) @(posedge clk); #2 kb_clk = 0;
        repeat (HALF) @(posedge clk); #2 kb_clk = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pp, input bit lat);
        @(posedge clk); #2;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        kb_data = !bad_stop;
        repeat (HALF) @(posedge clk); #2 kb_clk = 0;
        model_byte(b, !bad_par && !bad_stop, pp);
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk);
            if (c == FL + 2) force_pop = pp;
            if (c == FL + 3) force_pop = 0;
            if (lat && c == FL + 2) begin #1 check("latency_early", kv, 0); end
            if (lat && c == FL + 5) begin #1 check("latency_late", kv, 1); end
        end
        #2 kb_clk = 1;
        kb_data = 1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic send_partial(input int nbits);
        @(posedge clk); #2;
        ps2_bit(1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic do_pop();
        @(posedge clk); force_pop = 1;
        @(posedge clk); force_pop = 0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        auto_pop = 1;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        auto_pop = 0;
        #1;
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", kv, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, kv, 0);
        check({tag, "_code"}, kc, 0);
        check({tag, "_rel"}, krel, 0);
        check({tag, "_ext"}, kext, 0);
        check({tag, "_count"}, cnt, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_ferr"}, ferr, 0);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bit bp, bs;

        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #2 rst_n = 1;
        repeat (5) @(posedge clk);

        // Single make code with latency window
        send_frame(8'h1C, 0, 0, 0, 1);
        check("make_valid", kv, 1); check("make_code", kc, 8'h1C);
        check("make_rel", krel, 0); check("make_ext", kext, 0); check("make_count", cnt, 1);
        do_pop();
        check("pop_valid", kv, 0); check("pop_count", cnt, 0);

        // Extended break, then plain make
        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0, 0);
        check("brk_count", cnt, 1); check("brk_code", kc, 8'h75);
        check("brk_rel", krel, 1); check("brk_ext", kext, 1);
        send_frame(8'h1C, 0, 0, 0, 0);
        do_pop();
        check("after_code", kc, 8'h1C); check("after_rel", krel, 0); check("after_ext", kext, 0);
        do_pop();

        // Bad parity, bad stop
        send_frame(8'h1C, 1, 0, 0, 0);
        send_frame(8'h1C, 0, 1, 0, 0);
        check("bad_frames_err", err_seen, exp_err); check("bad_frames_count", cnt, 0);

        // Timeout mid-frame, then recovery
        send_partial(5);
        repeat (TO + 60) @(posedge clk);
        exp_err++;
        check("timeout_err", err_seen, exp_err);
        send_frame(8'h1C, 0, 0, 0, 0);
        check("timeout_recover_count", cnt, 1); check("timeout_recover_code", kc, 8'h1C);
        do_pop();

        // Short clock glitch in idle with data high
        @(posedge clk); #2 kb_clk = 0;
        repeat (FL - 1) @(posedge clk); #2 kb_clk = 1;
        repeat (20) @(posedge clk); #1;
        check("glitch_err", err_seen, exp_err); check("glitch_count", cnt, 0);

        // Random traffic with random pops
        auto_pop = 1;
        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hE0 || b == 8'hF0) b = 8'h5A;
            end
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 11) == 0);
            send_frame(b, bp, bs, 0, 0);
        end
        send_frame(8'h1C, 0, 0, 0, 0);
        drain();
        check("random_err", err_seen, exp_err); check("random_ovf", ovf, m_ovf);

        // Overflow with no pops, prefix cleared by dropped push
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 0, 0);
        check("full_count", cnt, 8); check("full_ovf", ovf, 0);
        send_frame(8'h09, 0, 0, 0, 0);
        check("ovf_count", cnt, 8); check("ovf_flag", ovf, m_ovf);
        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'h0A, 0, 0, 0, 0);
        check("ovf_count2", cnt, 8);
        drain();
        send_frame(8'h1C, 0, 0, 0, 0);
        check("ovf_after_ext", kext, 0); check("ovf_after_code", kc, 8'h1C);
        do_pop();

        // Pop while empty is ignored
        do_pop();
        check("empty_pop_count", cnt, 0);

        // Reset mid-frame with entries queued
        send_frame(8'h2C, 0, 0, 0, 0);
        send_frame(8'h3C, 0, 0, 0, 0);
        send_partial(3);
        kb_data = 1;
        rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_rel = 0; m_ext = 0; m_ovf = 0;
        repeat (4) @(posedge clk); #2 rst_n = 1;
        repeat (5) @(posedge clk);
        send_frame(8'h1C, 0, 0, 0, 0);
        check("midreset_count", cnt, 1); check("midreset_code", kc, 8'h1C);
        check("midreset_err", err_seen, exp_err);

        // Pop on the push cycle while full
        for (int i = 0; i < 7; i++) send_frame(8'h21 + 8'(i), 0, 0, 0, 0);
        check("simul_pre_count", cnt, 8);
        send_frame(8'h28, 0, 0, 1, 0);
        check("simul_count", cnt, 8); check("simul_ovf", ovf, m_ovf);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run length.
    initial begin
        #5000000;
        $display("FAIL watchdog: bench did not complete, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
